// File: rtl/izh_neuron_array.sv
// N Izhikevich neurons in register files, advanced one neuron per clock through a
// single shared saturating fixed-point datapath on each start pulse.
module izh_neuron_array #(
  parameter int N = 4,
  parameter int W = 18,
  parameter int FRAC = 16,
  parameter int AW = $clog2(N),
  parameter logic signed [W-1:0] VPEAK  = 18'sh0_4CCD,
  parameter logic signed [W-1:0] V_INIT = 18'sh3_4CCD,
  parameter logic signed [W-1:0] U_INIT = 18'sh3_CCCD,
  parameter logic [3:0] A_DEF = 4'd2,
  parameter logic [3:0] B_DEF = 4'd2,
  parameter logic signed [W-1:0] C_DEF  = 18'sh3_599A,
  parameter logic signed [W-1:0] D_DEF  = 18'sh0_147B,
  parameter logic signed [W-1:0] C14    = 18'sh1_6666
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          step_done,
  output logic [N-1:0]  spike_vec,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [2:0]    cfg_sel,
  input  logic [W-1:0]  cfg_data,
  input  logic [AW-1:0] mon_sel,
  output logic [W-1:0]  mon_v,
  output logic [7:0]    mon_spk
);

  localparam int XW = W + 4;
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q;
  logic [AW-1:0]       idx_q;
  logic                busy_q, done_q;
  logic [N-1:0]        spk_q, acc_q, acc_d;
  logic signed [W-1:0] v_q [N];
  logic signed [W-1:0] u_q [N];
  logic signed [W-1:0] c_q [N];
  logic signed [W-1:0] d_q [N];
  logic signed [W-1:0] i_q [N];
  logic [3:0]          a_q [N];
  logic [3:0]          b_q [N];

  function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] hi, lo;
    hi = PW'({(W-1){1'b1}});
    lo = ~hi;
    if (x > hi)      sat_w = hi[W-1:0];
    else if (x < lo) sat_w = lo[W-1:0];
    else             sat_w = x[W-1:0];
  endfunction

  logic signed [W-1:0]  v_c, u_c, i_c, c_c, d_c;
  logic [3:0]           a_c, b_c;
  logic signed [PW-1:0] prod_c;
  logic signed [W-1:0]  psq_c, vnew_c, unew_c, uspk_c;
  logic signed [XW-1:0] vx_c, ux_c, ix_c, sum_c, du_c;
  logic                 spike_c, cfg_ok;

  assign v_c = v_q[idx_q];
  assign u_c = u_q[idx_q];
  assign i_c = i_q[idx_q];
  assign c_c = c_q[idx_q];
  assign d_c = d_q[idx_q];
  assign a_c = a_q[idx_q];
  assign b_c = b_q[idx_q];

  // Shared datapath for the neuron selected by idx_q; widened to XW so the sum cannot wrap.
  always_comb begin
    vx_c    = XW'(v_c);
    ux_c    = XW'(u_c);
    ix_c    = XW'(i_c);
    prod_c  = PW'(v_c) * PW'(v_c);
    psq_c   = sat_w(prod_c >>> FRAC);
    sum_c   = XW'(psq_c) + vx_c + (vx_c >>> 2) + (XW'(C14) >>> 2) - (ux_c >>> 2) + (ix_c >>> 2);
    vnew_c  = sat_w(PW'(vx_c + (sum_c >>> 2)));
    du_c    = ((vx_c >>> b_c) - ux_c) >>> a_c;
    unew_c  = sat_w(PW'(ux_c + (du_c >>> 4)));
    uspk_c  = sat_w(PW'(ux_c + XW'(d_c)));
    spike_c = (v_c > VPEAK);
    acc_d   = acc_q;
    acc_d[idx_q] = spike_c;
  end

  assign cfg_ok = cfg_we && ({1'b0, cfg_addr} < (AW+1)'(N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      spk_q   <= '0;
      acc_q   <= '0;
      for (int k = 0; k < N; k++) begin
        v_q[k] <= V_INIT;
        u_q[k] <= U_INIT;
        c_q[k] <= C_DEF;
        d_q[k] <= D_DEF;
        i_q[k] <= '0;
        a_q[k] <= A_DEF;
        b_q[k] <= B_DEF;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Config lands on the same edge that accepts start, so the step sees it.
          if (cfg_ok) begin
            case (cfg_sel)
              3'd0: begin
                a_q[cfg_addr] <= cfg_data[3:0];
                b_q[cfg_addr] <= cfg_data[7:4];
              end
              3'd1: c_q[cfg_addr] <= cfg_data;
              3'd2: d_q[cfg_addr] <= cfg_data;
              3'd3: i_q[cfg_addr] <= cfg_data;
              3'd4: v_q[cfg_addr] <= cfg_data;
              3'd5: u_q[cfg_addr] <= cfg_data;
              default: ;
            endcase
          end
          if (start) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            acc_q   <= '0;
          end
        end
        S_RUN: begin
          v_q[idx_q] <= spike_c ? c_c : vnew_c;
          u_q[idx_q] <= spike_c ? uspk_c : unew_c;
          acc_q      <= acc_d;
          if (idx_q == AW'(N-1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            spk_q   <= acc_d;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign step_done = done_q;
  assign spike_vec = spk_q;
  assign mon_v     = v_q[mon_sel];
  assign mon_spk   = mon_v[W-1:W-8];

endmodule

// File: tb/tb_izh_neuron_array.sv
// Directed and randomized checks of izh_neuron_array against an integer reference model.
module tb_izh_neuron_array;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, step_done;
  logic [N-1:0]  spike_vec;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [2:0]    cfg_sel = '0;
  logic [17:0]   cfg_data = '0;
  logic [AW-1:0] mon_sel = '0;
  logic [17:0]   mon_v;
  logic [7:0]    mon_spk;

  izh_neuron_array dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .step_done(step_done),
    .spike_vec(spike_vec), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .mon_sel(mon_sel), .mon_v(mon_v), .mon_spk(mon_spk)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  longint mv[N], mu[N], mc[N], md[N], mi[N];
  int ma[N], mb[N];
  logic [N-1:0] mspk;

  // Reference math on plain integers: floor division by powers of two, clamp to 18 bits.
  function automatic longint fl(input longint x, input int s);
    longint d;
    d = longint'(1) << s;
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic longint sat(input longint x);
    if (x > 131071) return 131071;
    if (x < -131072) return -131072;
    return x;
  endfunction

  function automatic longint sx(input logic [17:0] x);
    longint r;
    r = $signed(x);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = -45875; mu[k] = -13107; mc[k] = -42598; md[k] = 5243;
      mi[k] = 0; ma[k] = 2; mb[k] = 2;
    end
    mspk = '0;
  endtask

  task automatic model_cfg(input int addr, input int sel, input logic [17:0] data);
    if (addr < N) begin
      case (sel)
        0: begin ma[addr] = int'(data[3:0]); mb[addr] = int'(data[7:4]); end
        1: mc[addr] = sx(data);
        2: md[addr] = sx(data);
        3: mi[addr] = sx(data);
        4: mv[addr] = sx(data);
        5: mu[addr] = sx(data);
        default: ;
      endcase
    end
  endtask

  task automatic model_step();
    longint v, u, p, s, du;
    for (int k = 0; k < N; k++) begin
      v = mv[k]; u = mu[k];
      if (v > 19661) begin
        mv[k] = mc[k];
        mu[k] = sat(u + md[k]);
        mspk[k] = 1'b1;
      end else begin
        p = sat(fl(v * v, 16));
        s = p + v + fl(v, 2) + fl(91750, 2) - fl(u, 2) + fl(mi[k], 2);
        du = fl(fl(v, mb[k]) - u, ma[k]);
        mv[k] = sat(v + fl(s, 2));
        mu[k] = sat(u + fl(du, 4));
        mspk[k] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [17:0] e;
    for (int k = 0; k < N; k++) begin
      mon_sel = k[AW-1:0];
      #1;
      e = mv[k][17:0];
      chk($sformatf("%s_v%0d", tag, k), mon_v, e);
      chk($sformatf("%s_spk%0d", tag, k), mon_spk, e[17:10]);
    end
  endtask

  task automatic cfg(input int addr, input int sel, input logic [17:0] data);
    cfg_we = 1'b1; cfg_addr = addr[AW-1:0]; cfg_sel = sel[2:0]; cfg_data = data;
    model_cfg(addr, sel, data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_step(input bit we, input int addr, input int sel,
                          input logic [17:0] data, input string tag);
    start = 1'b1;
    cfg_we = we; cfg_addr = addr[AW-1:0]; cfg_sel = sel[2:0]; cfg_data = data;
    if (we) model_cfg(addr, sel, data);
    tick();
    start = 1'b0; cfg_we = 1'b0;
    model_step();
    chk({tag, "_busy1"}, busy, 1);
    chk({tag, "_done_early"}, step_done, 0);
    repeat (N - 1) tick();
    chk({tag, "_done_tN"}, step_done, 0);
    tick();
    chk({tag, "_done"}, step_done, 1);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_spkvec"}, spike_vec, mspk);
    tick();
    chk({tag, "_done_clr"}, step_done, 0);
    chk({tag, "_busy0"}, busy, 0);
    check_all(tag);
  endtask

  initial begin
    int cnt, at;
    model_reset();
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", step_done, 0);
    chk("rst_spk", spike_vec, 0);
    check_all("rst");
    rst_n = 1'b1;
    tick();

    run_step(0, 0, 0, '0, "base");
    mon_sel = 2'd0; #1; chk("base_const_v0", mon_v, 18'h34DC2);
    mon_sel = 2'd3; #1; chk("base_const_v3", mon_v, 18'h34DC2);

    cfg(2, 4, 18'h04CCE);
    cfg(2, 2, 18'h0147B);
    run_step(0, 0, 0, '0, "spk2");
    chk("spk2_const_vec", spike_vec, 4'b0100);
    mon_sel = 2'd2; #1; chk("spk2_const_c", mon_v, 18'h3599A);

    cfg(2, 4, 18'h04CCD);
    run_step(0, 0, 0, '0, "eq");
    chk("eq_no_spike", spike_vec[2], 0);

    cfg(1, 5, 18'h1FFFF);
    cfg(1, 4, 18'h05000);
    run_step(0, 0, 0, '0, "usat");
    chk("usat_bit1", spike_vec[1], 1);
    run_step(0, 0, 0, '0, "usat_next");

    run_step(1, 0, 3, 18'h08000, "combo");

    // start held three cycles with a write attempted mid-step
    start = 1'b1;
    tick(); tick();
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_sel = 3'd4; cfg_data = 18'h01234;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    model_step();
    cnt = 0; at = -1;
    for (int c = 3; c < 14; c++) begin
      if (step_done) begin cnt++; at = c; end
      tick();
    end
    chk("held_done_cnt", cnt, 1);
    chk("held_done_at", at, N + 1);
    chk("held_spkvec", spike_vec, mspk);
    check_all("held");

    // reset in the middle of a step
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_busy", busy, 0);
    chk("mid_done", step_done, 0);
    chk("mid_spk", spike_vec, 0);
    check_all("mid");
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (step_done) cnt++;
      tick();
    end
    chk("mid_no_done", cnt, 0);
    run_step(0, 0, 0, '0, "after_rst");

    for (int it = 0; it < 16; it++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++)
        cfg(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 7)), 18'($urandom));
      run_step(bit'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
               int'($urandom_range(0, 7)), 18'($urandom), $sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
